// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA encrypt/decrypt blocks: FSM state encoding
// and the message-to-modulus width relation.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RED,
    ST_SQR,
    ST_MUL,
    ST_DONE
  } rsa_state_t;

  localparam int NW_FACTOR = 2;

  // Modulus/key width derived from the message width.
  function automatic int nw_of(input int width);
    return NW_FACTOR * width;
  endfunction

endpackage

// File: rtl/rsa_mod_mul.sv
// Iterative modular multiplier r = a*b mod n: MSB-first interleaved shift-add,
// one bit of a per cycle, with up to two conditional subtractions of n.
module rsa_mod_mul #(
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [NW-1:0] a,
  input  logic [NW-1:0] b,
  input  logic [NW-1:0] n,
  output logic          done,
  output logic [NW-1:0] r
);

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0] a_reg;
  logic [NW-1:0] b_reg;
  logic [NW-1:0] n_reg;
  logic [NW+1:0] acc_reg;
  logic [NW+1:0] acc_next;
  logic [NW+1:0] sum;
  logic [NW+1:0] once;
  logic [NW+1:0] n_ext;
  logic [CW-1:0] cnt_reg;
  logic          done_reg;

  // acc < n and b <= n keep 2*acc + b below 3n, so two subtractions suffice.
  always_comb begin
    n_ext    = {2'b00, n_reg};
    sum      = (acc_reg << 1) + (a_reg[NW-1] ? {2'b00, b_reg} : '0);
    once     = (sum >= n_ext) ? (sum - n_ext) : sum;
    acc_next = (once >= n_ext) ? (once - n_ext) : once;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (go) begin
      a_reg    <= a;
      b_reg    <= b;
      n_reg    <= n;
      acc_reg  <= '0;
      cnt_reg  <= CW'(NW);
      done_reg <= 1'b0;
    end else if (cnt_reg != '0) begin
      acc_reg  <= acc_next;
      a_reg    <= a_reg << 1;
      cnt_reg  <= cnt_reg - 1'b1;
      done_reg <= (cnt_reg == CW'(1));
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign done = done_reg;
  assign r    = acc_reg[NW-1:0];

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption m = c^d mod n by left-to-right square-and-multiply over
// rsa_mod_mul; CONST_TIME adds a discarded multiply on zero exponent bits.
module rsa_decrypt #(
  parameter int WIDTH      = 8,
  parameter int CONST_TIME = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   c,
  input  logic [2*WIDTH-1:0] d,
  input  logic [2*WIDTH-1:0] n,
  output logic [WIDTH-1:0]   m,
  output logic               busy,
  output logic               finish,
  output logic               err
);

  import rsa_pkg::*;

  localparam int NW = nw_of(WIDTH);
  localparam int IW = $clog2(NW);

  rsa_state_t    state_reg;
  logic [IW-1:0] idx_reg;
  logic [NW-1:0] d_reg;
  logic [NW-1:0] n_reg;
  logic [NW-1:0] base_reg;
  logic [NW-1:0] acc_reg;
  logic [WIDTH-1:0] m_reg;
  logic          busy_reg;
  logic          finish_reg;
  logic          err_reg;

  logic          go;
  logic [NW-1:0] mul_a;
  logic [NW-1:0] mul_b;
  logic [NW-1:0] mul_n;
  logic          mul_done;
  logic [NW-1:0] mul_r;
  logic [NW-1:0] new_acc;
  logic          take_mul;
  logic          last_bit;
  logic          complete;

  rsa_mod_mul #(.NW(NW)) u_mod_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .a    (mul_a),
    .b    (mul_b),
    .n    (mul_n),
    .done (mul_done),
    .r    (mul_r)
  );

  // Next operation is issued combinationally in the cycle the previous one
  // reports done, so operands come straight from the multiplier result.
  always_comb begin
    take_mul = d_reg[idx_reg] || (CONST_TIME != 0);
    last_bit = (idx_reg == '0);
    new_acc  = acc_reg;
    go       = 1'b0;
    mul_a    = acc_reg;
    mul_b    = acc_reg;
    mul_n    = n_reg;
    complete = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        mul_a = {{(NW-WIDTH){1'b0}}, c};
        mul_b = NW'(1);
        mul_n = n;
        go    = start && (n != '0);
      end
      ST_RED: begin
        new_acc = NW'(1);
        mul_a   = NW'(1);
        mul_b   = NW'(1);
        go      = mul_done;
      end
      ST_SQR: begin
        new_acc  = mul_r;
        mul_a    = mul_r;
        mul_b    = take_mul ? base_reg : mul_r;
        go       = mul_done && (take_mul || !last_bit);
        complete = mul_done && !take_mul && last_bit;
      end
      ST_MUL: begin
        new_acc  = d_reg[idx_reg] ? mul_r : acc_reg;
        mul_a    = new_acc;
        mul_b    = new_acc;
        go       = mul_done && !last_bit;
        complete = mul_done && last_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      d_reg      <= '0;
      n_reg      <= '0;
      base_reg   <= '0;
      acc_reg    <= '0;
      m_reg      <= '0;
      busy_reg   <= 1'b0;
      finish_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            d_reg    <= d;
            n_reg    <= n;
            busy_reg <= 1'b1;
            if (n != '0) begin
              state_reg <= ST_RED;
            end else begin
              state_reg  <= ST_DONE;
              finish_reg <= 1'b1;
              err_reg    <= 1'b1;
              m_reg      <= '0;
            end
          end
        end
        ST_RED: begin
          if (mul_done) begin
            base_reg  <= mul_r;
            acc_reg   <= new_acc;
            idx_reg   <= IW'(NW - 1);
            state_reg <= ST_SQR;
          end
        end
        ST_SQR: begin
          if (mul_done) begin
            acc_reg <= new_acc;
            if (take_mul) begin
              state_reg <= ST_MUL;
            end else if (!last_bit) begin
              idx_reg <= idx_reg - 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            acc_reg <= new_acc;
            if (!last_bit) begin
              idx_reg   <= idx_reg - 1'b1;
              state_reg <= ST_SQR;
            end
          end
        end
        ST_DONE: begin
          finish_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (complete) begin
        state_reg  <= ST_DONE;
        finish_reg <= 1'b1;
        m_reg      <= new_acc[WIDTH-1:0];
        err_reg    <= |new_acc[NW-1:WIDTH];
      end
    end
  end

  assign m      = m_reg;
  assign busy   = busy_reg;
  assign finish = finish_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench: leaky and constant-time instances run side by side
// against a right-to-left modular exponentiation model.
module tb_rsa_decrypt;

  localparam int WIDTH  = 8;
  localparam int NWB    = 16;
  localparam int BUDGET = 800;

  logic              clk;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  c;
  logic [NWB-1:0]    d;
  logic [NWB-1:0]    n;
  logic [WIDTH-1:0]  m0, m1;
  logic              busy0, busy1, finish0, finish1, err0, err1;

  int n_vec = 0;
  int n_err = 0;

  rsa_decrypt #(.WIDTH(WIDTH), .CONST_TIME(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .c(c), .d(d), .n(n),
    .m(m0), .busy(busy0), .finish(finish0), .err(err0)
  );

  rsa_decrypt #(.WIDTH(WIDTH), .CONST_TIME(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .c(c), .d(d), .n(n),
    .m(m1), .busy(busy1), .finish(finish1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint powmod(input longint base, input longint e, input longint md);
    longint r = 1 % md;
    longint x = base % md;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * x) % md;
      x = (x * x) % md;
      e = e / 2;
    end
    return r;
  endfunction

  task automatic run_case(input logic [7:0] cv, input logic [15:0] dv,
                          input logic [15:0] nv, input bit spam);
    longint res;
    int     exp_m, exp_err, exp_lat0, exp_lat1;
    int     lat0, lat1, mo0, mo1, eo0, eo1;
    bit     got0, got1, fresh0;

    if (nv == 0) begin
      exp_m = 0; exp_err = 1; exp_lat0 = 1; exp_lat1 = 1;
    end else begin
      res      = powmod(longint'(cv), longint'(dv), longint'(nv));
      exp_m    = int'(res % 256);
      exp_err  = (res >= 256) ? 1 : 0;
      exp_lat0 = (NWB + 1) * (1 + NWB + $countones(dv)) + 1;
      exp_lat1 = (NWB + 1) * (1 + NWB + NWB) + 1;
    end

    got0 = 0; got1 = 0; lat0 = 0; lat1 = 0;
    mo0 = 0; mo1 = 0; eo0 = 0; eo1 = 0;
    c = cv; d = dv; n = nv; start = 1'b1;
    for (int lat = 1; lat <= BUDGET; lat++) begin
      @(posedge clk); #1;
      if (lat == 1) begin
        start = 1'b0;
        check("busy0_after_start", 32'(busy0), 32'd1);
        check("busy1_after_start", 32'(busy1), 32'd1);
      end
      c = WIDTH'($urandom);
      d = NWB'($urandom);
      n = NWB'($urandom);
      fresh0 = 0;
      if (!got0 && finish0) begin
        got0 = 1; lat0 = lat; mo0 = int'(m0); eo0 = int'(err0); fresh0 = 1;
      end
      if (!got1 && finish1) begin
        got1 = 1; lat1 = lat; mo1 = int'(m1); eo1 = int'(err1);
      end
      start = (spam && (!got0 || fresh0)) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (got0 && got1) break;
    end

    check("finish0_seen", 32'(got0), 32'd1);
    check("finish1_seen", 32'(got1), 32'd1);
    check("lat0", 32'(lat0), 32'(exp_lat0));
    check("lat1", 32'(lat1), 32'(exp_lat1));
    check("err0", 32'(eo0), 32'(exp_err));
    check("err1", 32'(eo1), 32'(exp_err));
    if (nv != 0) begin
      check("m0", 32'(mo0), 32'(exp_m));
      check("m1", 32'(mo1), 32'(exp_m));
    end

    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("busy0_idle", 32'(busy0), 32'd0);
    check("busy1_idle", 32'(busy1), 32'd0);
    $display("case c=%0d d=%0d n=%0d spam=%0d -> m=%0d/%0d err=%0d/%0d lat=%0d/%0d",
             cv, dv, nv, spam, mo0, mo1, eo0, eo1, lat0, lat1);
  endtask

  initial begin
    bit seen;
    logic [7:0]  rc;
    logic [15:0] rd, rn;

    rst = 1'b1; start = 1'b0; c = '0; d = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0", 32'(m0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_finish0", 32'(finish0), 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_finish1", 32'(finish1), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_case(8'd48, 16'd103, 16'd143, 1'b0);
    run_case(8'd48, 16'd1, 16'd143, 1'b0);
    run_case(8'd48, 16'hFFFF, 16'd143, 1'b0);
    run_case(8'd48, 16'd0, 16'd143, 1'b0);
    run_case(8'd48, 16'd103, 16'd1, 1'b0);
    run_case(8'd48, 16'd103, 16'd0, 1'b0);
    run_case(8'd200, 16'd2753, 16'd3233, 1'b0);
    run_case(8'd200, 16'd7, 16'd13, 1'b1);
    run_case(8'd48, 16'd103, 16'd143, 1'b1);

    // Abort in the middle of the squaring phase.
    c = 8'd48; d = 16'd103; n = 16'd143; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_m0", 32'(m0), 32'd0);
    check("midrst_busy0", 32'(busy0), 32'd0);
    check("midrst_finish0", 32'(finish0), 32'd0);
    check("midrst_m1", 32'(m1), 32'd0);
    check("midrst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (BUDGET) begin
      @(posedge clk); #1;
      if (finish0 || finish1) seen = 1;
    end
    check("midrst_no_finish", 32'(seen), 32'd0);
    $display("reset mid-operation: finish observed afterwards=%0d", seen);
    run_case(8'd48, 16'd103, 16'd143, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rc = 8'($urandom);
      rd = 16'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      run_case(rc, rd, rn, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
